// File: rtl/hub75_linebuffer_ring_if.sv
// Writer/reader bundle for the HUB75 multi-line ring buffer.
// master = fetch logic plus shifter side, slave = the buffer itself.
interface hub75_linebuffer_ring_if #(
    parameter int N_WORDS    = 1,
    parameter int WORD_WIDTH = 24,
    parameter int ADDR_WIDTH = 6,
    parameter int LINE_BITS  = 1
);
    logic [ADDR_WIDTH-1:0]         wr_addr;
    logic [N_WORDS*WORD_WIDTH-1:0] wr_data;
    logic [N_WORDS-1:0]            wr_mask;
    logic                          wr_ena;
    logic                          wr_commit;
    logic                          wr_rdy;
    logic                          wr_ovf;
    logic [ADDR_WIDTH-1:0]         rd_addr;
    logic                          rd_ena;
    logic [N_WORDS*WORD_WIDTH-1:0] rd_data;
    logic                          rd_release;
    logic                          rd_valid;
    logic [LINE_BITS:0]            level;

    modport master (
        output wr_addr, wr_data, wr_mask, wr_ena, wr_commit,
        output rd_addr, rd_ena, rd_release,
        input  wr_rdy, wr_ovf, rd_data, rd_valid, level
    );

    modport slave (
        input  wr_addr, wr_data, wr_mask, wr_ena, wr_commit,
        input  rd_addr, rd_ena, rd_release,
        output wr_rdy, wr_ovf, rd_data, rd_valid, level
    );
endinterface

// File: rtl/hub75_linebuffer_ring.sv
// Ring of 2^LINE_BITS line slots between frame-buffer fetch and the HUB75 shifter.
// Latency: 1-cycle registered read; commit/release visible on flags the next cycle.
// Backpressure: wr_rdy low when all slots committed; blocked writes/commits set sticky wr_ovf.
module hub75_linebuffer_ring #(
    parameter int N_WORDS    = 1,
    parameter int WORD_WIDTH = 24,
    parameter int ADDR_WIDTH = 6,
    parameter int LINE_BITS  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hub75_linebuffer_ring_if.slave  bus
);
    localparam int DATA_W = N_WORDS * WORD_WIDTH;
    localparam int DEPTH  = 1 << (ADDR_WIDTH + LINE_BITS);
    localparam logic [LINE_BITS:0] FULL_LVL = (LINE_BITS+1)'(1 << LINE_BITS);

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [LINE_BITS-1:0] wr_line;
    logic [LINE_BITS-1:0] rd_line;
    logic [LINE_BITS:0]   level;
    logic                 wr_ovf;
    logic [DATA_W-1:0]    rd_q;

    logic wr_rdy;
    logic rd_valid;
    logic wr_acc;
    logic commit_acc;
    logic release_acc;

    assign wr_rdy      = (level != FULL_LVL);
    assign rd_valid    = (level != '0);
    assign wr_acc      = bus.wr_ena & wr_rdy;
    assign commit_acc  = bus.wr_commit & wr_rdy;
    assign release_acc = bus.rd_release & rd_valid;

    // Per-word masked write; unmasked words keep their previous content.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < N_WORDS; i++) begin
                if (bus.wr_mask[i]) begin
                    mem[{wr_line, bus.wr_addr}][i*WORD_WIDTH +: WORD_WIDTH] <=
                        bus.wr_data[i*WORD_WIDTH +: WORD_WIDTH];
                end
            end
        end
    end

    // Read uses the pre-release rd_line when a release lands in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (bus.rd_ena) begin
            rd_q <= mem[{rd_line, bus.rd_addr}];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_line <= '0;
            rd_line <= '0;
            level   <= '0;
            wr_ovf  <= 1'b0;
        end else begin
            if (commit_acc) begin
                wr_line <= wr_line + 1'b1;
            end
            if (release_acc) begin
                rd_line <= rd_line + 1'b1;
            end
            case ({commit_acc, release_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if ((bus.wr_ena | bus.wr_commit) & ~wr_rdy) begin
                wr_ovf <= 1'b1;
            end
        end
    end

    assign bus.wr_rdy   = wr_rdy;
    assign bus.wr_ovf   = wr_ovf;
    assign bus.rd_data  = rd_q;
    assign bus.rd_valid = rd_valid;
    assign bus.level    = level;
endmodule

// File: tb/tb_hub75_linebuffer_ring.sv
// Directed bench: a two-slot instance for masking/fill/handshake/reset, a four-slot one for ordering.
module tb_hub75_linebuffer_ring;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hub75_linebuffer_ring_if #(.N_WORDS(2), .WORD_WIDTH(24), .ADDR_WIDTH(6), .LINE_BITS(1)) b0 ();
    hub75_linebuffer_ring_if #(.N_WORDS(2), .WORD_WIDTH(24), .ADDR_WIDTH(6), .LINE_BITS(2)) b1 ();

    hub75_linebuffer_ring #(.N_WORDS(2), .WORD_WIDTH(24), .ADDR_WIDTH(6), .LINE_BITS(1)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0.slave)
    );
    hub75_linebuffer_ring #(.N_WORDS(2), .WORD_WIDTH(24), .ADDR_WIDTH(6), .LINE_BITS(2)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [47:0] sb_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        b0.wr_ena = 0; b0.wr_commit = 0; b0.rd_ena = 0; b0.rd_release = 0;
        b1.wr_ena = 0; b1.wr_commit = 0; b1.rd_ena = 0; b1.rd_release = 0;
    endtask

    // Instance 0: optional write, commit and release in one cycle.
    task automatic op0(input bit we, input logic [5:0] a, input logic [47:0] d,
                       input logic [1:0] m, input bit cm, input bit rl);
        b0.wr_ena = we; b0.wr_addr = a; b0.wr_data = d; b0.wr_mask = m;
        b0.wr_commit = cm; b0.rd_release = rl;
        tick();
        idle_all();
    endtask

    task automatic rd0(input string tag, input logic [5:0] a, input logic [47:0] exp);
        b0.rd_ena = 1; b0.rd_addr = a;
        sb_q.push_back(exp);
        tick();
        b0.rd_ena = 0;
        chk(tag, 64'(b0.rd_data), 64'(sb_q.pop_front()));
    endtask

    task automatic op1(input bit we, input logic [5:0] a, input logic [47:0] d, input bit cm, input bit rl);
        b1.wr_ena = we; b1.wr_addr = a; b1.wr_data = d; b1.wr_mask = 2'b11;
        b1.wr_commit = cm; b1.rd_release = rl;
        tick();
        idle_all();
    endtask

    task automatic rd1(input string tag, input logic [5:0] a, input logic [47:0] exp);
        b1.rd_ena = 1; b1.rd_addr = a;
        sb_q.push_back(exp);
        tick();
        b1.rd_ena = 0;
        chk(tag, 64'(b1.rd_data), 64'(sb_q.pop_front()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        b0.wr_addr = '0; b0.wr_data = '0; b0.wr_mask = '0; b0.rd_addr = '0;
        b1.wr_addr = '0; b1.wr_data = '0; b1.wr_mask = '0; b1.rd_addr = '0;
        idle_all();
        #12;
        chk("rst_wr_rdy",   64'(b0.wr_rdy),   64'd1);
        chk("rst_rd_valid", 64'(b0.rd_valid), 64'd0);
        chk("rst_level",    64'(b0.level),    64'd0);
        chk("rst_rd_data",  64'(b0.rd_data),  64'd0);
        chk("rst_wr_ovf",   64'(b0.wr_ovf),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Masked write: second write updates word0 only.
        op0(1, 6'd5, {24'hBBBBBB, 24'hAAAAAA}, 2'b11, 0, 0);
        op0(1, 6'd5, {24'h222222, 24'h111111}, 2'b01, 0, 0);
        op0(0, 6'd0, '0, 2'b00, 1, 0);
        chk("mask_level",    64'(b0.level),    64'd1);
        chk("mask_rd_valid", 64'(b0.rd_valid), 64'd1);
        rd0("mask_read", 6'd5, {24'hBBBBBB, 24'h111111});
        op0(0, 6'd0, '0, 2'b00, 0, 1);
        chk("mask_rel_level", 64'(b0.level), 64'd0);

        // Commit+release at level 1; the write in the commit cycle lands in the committed line.
        op0(1, 6'd0, 48'hC0C0C0_C1C1C1, 2'b11, 1, 0);
        op0(1, 6'd0, 48'hD0D0D0_D1D1D1, 2'b11, 1, 1);
        chk("sim1_level",  64'(b0.level),  64'd1);
        chk("sim1_wr_ovf", 64'(b0.wr_ovf), 64'd0);
        rd0("sim1_read", 6'd0, 48'hD0D0D0_D1D1D1);

        // Commit+release when full: release accepted, commit and write blocked.
        op0(1, 6'd0, 48'hE0E0E0_E1E1E1, 2'b11, 1, 0);
        chk("full_level",  64'(b0.level),  64'd2);
        chk("full_wr_rdy", 64'(b0.wr_rdy), 64'd0);
        op0(1, 6'd0, 48'hF0F0F0_F1F1F1, 2'b11, 1, 1);
        chk("simf_level",  64'(b0.level),  64'd1);
        chk("simf_wr_ovf", 64'(b0.wr_ovf), 64'd1);
        chk("simf_wr_rdy", 64'(b0.wr_rdy), 64'd1);
        rd0("simf_read", 6'd0, 48'hE0E0E0_E1E1E1);

        // Asynchronous reset mid-line with level 1.
        b0.wr_ena = 1; b0.wr_addr = 6'd3; b0.wr_data = 48'h123456_654321; b0.wr_mask = 2'b11;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_level",    64'(b0.level),    64'd0);
        chk("arst_wr_rdy",   64'(b0.wr_rdy),   64'd1);
        chk("arst_rd_valid", 64'(b0.rd_valid), 64'd0);
        chk("arst_wr_ovf",   64'(b0.wr_ovf),   64'd0);
        chk("arst_rd_data",  64'(b0.rd_data),  64'd0);
        idle_all();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fill both slots, then attempt an overflowing write+commit.
        for (int i = 0; i < 4; i++)
            op0(1, 6'(i), 48'hA00000_0A0000 + 48'(i), 2'b11, (i == 3), 0);
        for (int i = 0; i < 4; i++)
            op0(1, 6'(i), 48'hB00000_0B0000 + 48'(i), 2'b11, (i == 3), 0);
        chk("fill_level",    64'(b0.level),    64'd2);
        chk("fill_wr_rdy",   64'(b0.wr_rdy),   64'd0);
        chk("fill_rd_valid", 64'(b0.rd_valid), 64'd1);
        op0(1, 6'd0, 48'hDEADBE_EFDEAD, 2'b11, 1, 0);
        chk("ovf_flag",  64'(b0.wr_ovf), 64'd1);
        chk("ovf_level", 64'(b0.level),  64'd2);
        for (int i = 0; i < 4; i++)
            rd0("fill_line0", 6'(i), 48'hA00000_0A0000 + 48'(i));
        op0(0, 6'd0, '0, 2'b00, 0, 1);
        chk("rel_wr_rdy", 64'(b0.wr_rdy), 64'd1);
        chk("rel_level",  64'(b0.level),  64'd1);
        for (int i = 0; i < 4; i++)
            rd0("fill_line1", 6'(i), 48'hB00000_0B0000 + 48'(i));

        // Four-slot ordering: tags come back in commit order.
        for (int k = 0; k < 4; k++) begin
            op1(1, 6'd1, 48'h5A0000_A50000 + 48'(k), 1, 0);
        end
        chk("ord_full_wr_rdy", 64'(b1.wr_rdy), 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk("ord_level", 64'(b1.level), 64'(4 - k));
            rd1("ord_tag", 6'd1, 48'h5A0000_A50000 + 48'(k));
            op1(0, 6'd0, '0, 0, 1);
        end
        chk("ord_level_end",    64'(b1.level),    64'd0);
        chk("ord_rd_valid_end", 64'(b1.rd_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
